// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: data accesses win over instruction fetches.
// Optional wait-limit abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 inputReady,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] fetch_count,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] address_q, address_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic [WORD_SIZE-1:0] fetch_count_q, fetch_count_d;
    logic                 readm_q, readm_d;
    logic                 writem_q, writem_d;
    logic                 i_ack_q, i_ack_d;
    logic                 d_ack_q, d_ack_d;
    logic                 finish;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        fetch_count_d = fetch_count_q;
        readm_d       = readm_q;
        writem_d      = writem_q;
        i_ack_d       = 1'b0;
        d_ack_d       = 1'b0;
        finish        = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                // The ack cycle never grants, so a still-held request is not served twice.
                if (!(i_ack_q || d_ack_q)) begin
                    if (d_req) begin
                        state_d     = StBusyD;
                        address_d   = d_addr;
                        mem_wdata_d = d_wdata;
                        readm_d     = !d_we;
                        writem_d    = d_we;
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt_d  = 8'd0;
`endif
                    end else if (i_req) begin
                        state_d     = StBusyI;
                        address_d   = i_addr;
                        mem_wdata_d = d_wdata;
                        readm_d     = 1'b1;
                        writem_d    = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt_d  = 8'd0;
`endif
                    end
                end
            end
            StBusyI, StBusyD: begin
                if (inputReady) begin
                    finish = 1'b1;
                    if (readm_q) begin
                        rdata_d = mem_rdata;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (wait_cnt_q == TimeoutLast) begin
                    finish        = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
`endif
                end
                if (finish) begin
                    state_d  = StIdle;
                    readm_d  = 1'b0;
                    writem_d = 1'b0;
                    if (state_q == StBusyI) begin
                        i_ack_d       = 1'b1;
                        fetch_count_d = fetch_count_q + WORD_SIZE'(1);
                    end else begin
                        d_ack_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            address_q     <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            fetch_count_q <= '0;
            readm_q       <= 1'b0;
            writem_q      <= 1'b0;
            i_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            fetch_count_q <= fetch_count_d;
            readm_q       <= readm_d;
            writem_q      <= writem_d;
            i_ack_q       <= i_ack_d;
            d_ack_q       <= d_ack_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q    <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign rdata       = rdata_q;
    assign readM       = readm_q;
    assign writeM      = writem_q;
    assign address     = address_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = (state_q != StIdle);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; a narrow second instance covers counter wrap.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        i_req, d_req, d_we, inputReady;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ack, d_ack, readM, writeM, busy, timeout_err;
    logic [15:0] rdata, address, mem_wdata, fetch_count;

    logic        w_i_req, w_ready;
    logic        w_i_ack, w_d_ack, w_readM, w_writeM, w_busy, w_timeout_err;
    logic [7:0]  w_rdata, w_address, w_mem_wdata, w_fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.WORD_SIZE(16), .TIMEOUT_CYCLES(255)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .readM(readM), .writeM(writeM), .address(address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .inputReady(inputReady),
        .busy(busy), .fetch_count(fetch_count), .timeout_err(timeout_err)
    );

    mem_port_arbiter #(.WORD_SIZE(8), .TIMEOUT_CYCLES(255)) u_wrap (
        .clk(clk), .reset_n(reset_n),
        .i_req(w_i_req), .i_addr(8'h33), .i_ack(w_i_ack),
        .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(8'h00), .d_ack(w_d_ack),
        .rdata(w_rdata), .readM(w_readM), .writeM(w_writeM), .address(w_address),
        .mem_wdata(w_mem_wdata), .mem_rdata(8'hA5), .inputReady(w_ready),
        .busy(w_busy), .fetch_count(w_fetch_count), .timeout_err(w_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrap_fetch();
        w_i_req = 1'b1;
        tick();
        w_ready = 1'b1;
        tick();
        w_i_req = 1'b0;
        w_ready = 1'b0;
        tick();
    endtask

    // Strobes must never overlap, and busy is only a function of state.
    always @(negedge clk) begin
        if (reset_n && readM && writeM) begin
            check("strobe_overlap", 32'(readM & writeM), 32'd0);
        end
    end

    initial begin
        reset_n = 1'b0;
        {i_req, d_req, d_we, inputReady, w_i_req, w_ready} = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_strobes", {readM, writeM, i_ack, d_ack}, 0);
        check("rst_address", address, 0);
        check("rst_rdata", rdata, 0);
        check("rst_fetch_count", fetch_count, 0);
        check("rst_timeout_err", timeout_err, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Fetch read, memory answers three cycles after readM.
        i_req = 1'b1; i_addr = 16'h0010;
        tick();
        check("fetch_busy", busy, 1);
        check("fetch_readM", readM, 1);
        check("fetch_writeM", writeM, 0);
        check("fetch_address", address, 16'h0010);
        tick();
        tick();
        check("fetch_hold_readM", readM, 1);
        check("fetch_no_ack_yet", i_ack, 0);
        inputReady = 1'b1; mem_rdata = 16'h6A01;
        tick();
        check("fetch_i_ack", i_ack, 1);
        check("fetch_d_ack", d_ack, 0);
        check("fetch_rdata", rdata, 16'h6A01);
        check("fetch_count_1", fetch_count, 1);
        check("fetch_done_readM", readM, 0);
        check("fetch_done_busy", busy, 0);
        i_req = 1'b0; inputReady = 1'b0;
        tick();
        check("fetch_ack_one_cycle", i_ack, 0);

        // inputReady while idle is ignored.
        inputReady = 1'b1; mem_rdata = 16'h9999;
        tick();
        check("idle_ready_busy", busy, 0);
        check("idle_ready_acks", {i_ack, d_ack}, 0);
        check("idle_ready_rdata", rdata, 16'h6A01);
        inputReady = 1'b0;
        tick();

        // Write; request dropped mid-transaction still completes.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'hBEEF; mem_rdata = 16'h1234;
        tick();
        check("wr_writeM", writeM, 1);
        check("wr_readM", readM, 0);
        check("wr_mem_wdata", mem_wdata, 16'hBEEF);
        check("wr_address", address, 16'h0020);
        d_req = 1'b0; d_wdata = 16'h0000;
        tick();
        check("wr_dropped_busy", busy, 1);
        check("wr_hold_wdata", mem_wdata, 16'hBEEF);
        inputReady = 1'b1;
        tick();
        check("wr_d_ack", d_ack, 1);
        check("wr_writeM_clr", writeM, 0);
        check("wr_rdata_kept", rdata, 16'h6A01);
        inputReady = 1'b0; d_we = 1'b0;
        tick();

        // Contention: data first, one idle gap, then fetch.
        i_req = 1'b1; i_addr = 16'h0080;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        tick();
        check("cont_d_address", address, 16'h0040);
        check("cont_d_readM", readM, 1);
        inputReady = 1'b1; mem_rdata = 16'h5555;
        tick();
        check("cont_d_ack", {d_ack, i_ack}, 2'b10);
        check("cont_d_rdata", rdata, 16'h5555);
        d_req = 1'b0; inputReady = 1'b0;
        tick();
        check("cont_gap_busy", busy, 0);
        tick();
        check("cont_i_busy", busy, 1);
        check("cont_i_address", address, 16'h0080);
        inputReady = 1'b1; mem_rdata = 16'h7777;
        tick();
        check("cont_i_ack", {d_ack, i_ack}, 2'b01);
        check("cont_i_rdata", rdata, 16'h7777);
        check("cont_fetch_count", fetch_count, 2);
        i_req = 1'b0; inputReady = 1'b0;
        tick();

        // Reset in the middle of a fetch.
        i_req = 1'b1; i_addr = 16'h0099;
        tick();
        check("mid_rst_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_strobes", {readM, writeM, i_ack, d_ack}, 0);
        check("mid_rst_address", address, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_fetch_count", fetch_count, 0);
        tick();
        check("mid_rst_no_ack", i_ack, 0);
        reset_n = 1'b1;
        tick();
        check("post_rst_grant", {busy, readM}, 2'b11);
        check("post_rst_address", address, 16'h0099);
        inputReady = 1'b1; mem_rdata = 16'h0042;
        tick();
        check("post_rst_ack", i_ack, 1);
        check("post_rst_count", fetch_count, 1);
        i_req = 1'b0; inputReady = 1'b0;
        tick();

        // Memory never answers.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0044;
        tick();
        check("to_grant", busy, 1);
`ifdef MEM_ARB_TIMEOUT_EN
        repeat (254) tick();
        check("to_still_busy", {busy, readM}, 2'b11);
        tick();
        check("to_d_ack", d_ack, 1);
        check("to_readM", readM, 0);
        check("to_err", timeout_err, 1);
        check("to_rdata_kept", rdata, 16'h0042);
        d_req = 1'b0;
        tick();
        check("to_err_sticky", timeout_err, 1);
        check("to_ack_pulse", d_ack, 0);
`else
        repeat (300) tick();
        check("to_readM_held", readM, 1);
        check("to_busy_held", busy, 1);
        check("to_err_zero", timeout_err, 0);
        check("to_no_ack", d_ack, 0);
        inputReady = 1'b1;
        tick();
        check("to_late_ack", d_ack, 1);
        d_req = 1'b0; inputReady = 1'b0;
        tick();
`endif

        // Fetch counter wrap on the narrow instance.
        for (int k = 0; k < 255; k++) wrap_fetch();
        check("wrap_max", w_fetch_count, 8'hFF);
        wrap_fetch();
        check("wrap_zero", w_fetch_count, 8'h00);
        check("wrap_rdata", w_rdata, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
